// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - tagged direct-mapped BTB + 2-bit PHT predictor, optional gshare history (BP_GSHARE_HIST_EN)
module branch_predictor_gshare #(
  parameter int XLEN        = 64,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PCUpdate,
  input  logic [XLEN-1:0] targetUpdate,
  input  logic            takenUpdate,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] PCPrediction
);

  localparam int BI_W  = $clog2(BTB_ENTRIES);
  localparam int PI_W  = $clog2(PHT_ENTRIES);
  localparam int TAG_W = XLEN - 2;

  logic              btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]   btb_target [BTB_ENTRIES];
  logic [1:0]        pht        [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr;

  logic [BI_W-1:0] rd_bi;
  logic [BI_W-1:0] wr_bi;
  logic [PI_W-1:0] rd_pi;
  logic [PI_W-1:0] wr_pi;
  logic            hit;
  logic [1:0]      pht_next;
  logic            unused_low_bits;

  // The byte offset within a word never affects indexing or tagging.
  assign unused_low_bits = ^{PC[1:0], PCUpdate[1:0]};

  assign rd_bi = PC[BI_W+1:2];
  assign wr_bi = PCUpdate[BI_W+1:2];
  // History is zero-extended; when history is compiled out it is a constant 0.
  assign rd_pi = PC[PI_W+1:2] ^ PI_W'(ghr);
  assign wr_pi = PCUpdate[PI_W+1:2] ^ PI_W'(ghr);

  assign PCPlus4 = PC + XLEN'(4);

  // Zero-latency prediction: redirect only on a tag hit with a taken-leaning counter.
  always_comb begin
    hit = btb_valid[rd_bi] && (btb_tag[rd_bi] == PC[XLEN-1:2]);
    if (hit && pht[rd_pi][1]) PCPrediction = btb_target[rd_bi];
    else                      PCPrediction = PCPlus4;
  end

  // Saturating counter step for the entry being trained.
  always_comb begin
    pht_next = pht[wr_pi];
    if (takenUpdate && pht[wr_pi] != 2'b11)       pht_next = pht[wr_pi] + 2'b01;
    else if (!takenUpdate && pht[wr_pi] != 2'b00) pht_next = pht[wr_pi] - 2'b01;
  end

  // Table state: full clear in one reset cycle, otherwise train on resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
      for (int j = 0; j < PHT_ENTRIES; j++) pht[j] <= 2'b01;
    end else if (we) begin
      pht[wr_pi] <= pht_next;
      if (takenUpdate) begin
        btb_valid[wr_bi]  <= 1'b1;
        btb_tag[wr_bi]    <= PCUpdate[XLEN-1:2];
        btb_target[wr_bi] <= targetUpdate;
      end
    end
  end

`ifdef BP_GSHARE_HIST_EN
  // Global history shifts in each resolved direction, newest in bit 0.
  always_ff @(posedge clk) begin
    if (reset)   ghr <= '0;
    else if (we) ghr <= GHR_BITS'({ghr, takenUpdate});
  end
`else
  assign ghr = '0;
`endif

endmodule
